vc_sync_fifo: RTL and testbench
===============================

Name: vc_sync_fifo

Overview:
- Parametrised single-clock, multi-channel FIFO; next generation of the NoC router input buffer.
- Holds NUM_VC independent virtual-channel queues, each DEPTH entries of DATA_WIDTH bits.
- One write port and one read port, each steered by a VC index.
- Adds per-VC almost-full back-pressure, per-VC occupancy-driven flags, a registered read with a valid strobe, and optional error capture.

Parameters:
- DATA_WIDTH, 32, flit width in bits.
- DEPTH, 4, entries per VC; power of two, at least 2.
- NUM_VC, 2, number of virtual channels; at least 1.
- AFULL_LEVEL, 3, per-VC occupancy at or above which write_almost_full asserts; range 1..DEPTH.
- Localparam VC_W = max(1, clog2(NUM_VC)).
- Localparam CNT_W = clog2(DEPTH+1).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- write_inc  in  1  write request.
- write_vc  in  VC_W  target VC of the write.
- data_in  in  DATA_WIDTH  write data.
- read_inc  in  1  read request.
- read_vc  in  VC_W  source VC of the read.
- data_out  out  DATA_WIDTH  registered read data.
- read_valid  out  1  data_out holds a newly popped flit this cycle.
- write_full  out  NUM_VC  bit v = VC v holds DEPTH entries.
- write_almost_full  out  NUM_VC  bit v = count[v] >= AFULL_LEVEL.
- read_empty  out  NUM_VC  bit v = VC v holds 0 entries.

Behaviour:
- Storage:
  - NUM_VC*DEPTH word array.
  - Per-VC write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Per-VC count, CNT_W bits.
- Reset (reset=0, asynchronous):
  - All pointers and counts go to 0.
  - data_out = 0, read_valid = 0.
  - write_full = 0, write_almost_full = 0, read_empty = all ones.
  - Memory contents are not cleared.
- Write acceptance:
  - Accepted when write_inc=1, write_vc<NUM_VC, and write_full[write_vc]=0, with the flag taken as registered at the start of the cycle.
  - On accept: mem[write_vc][wptr] <= data_in, and wptr increments.
- Read acceptance:
  - Accepted when read_inc=1, read_vc<NUM_VC, and read_empty[read_vc]=0, with the flag taken at the start of the cycle.
  - On accept: data_out <= mem[read_vc][rptr], rptr increments, and read_valid=1 on the next cycle.
  - On no accept: read_valid=0 next cycle and data_out holds its previous value.
- Latency:
  - Read data appears one clock after the accepting edge.
  - A written flit is readable from the cycle after its write; no same-cycle write-through.
- Count update per VC:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - Unchanged when both are accepted on the same VC.
- Flags are combinational decodes of the registered counts, so they update the cycle after the accepting edge.
- Boundary conditions:
  - Write to a full VC is dropped, even if a read of that VC is accepted in the same cycle.
  - Read from an empty VC is dropped, even with a same-cycle write to that VC.
  - An out-of-range VC index drops the request.
  - Simultaneous write and read on different VCs are independent.
  - Pointer wrap from DEPTH-1 to 0 is silent.
  - Reset asserted mid-operation empties every VC immediately; queued data is lost.

Optional Feature:
- Macro: VC_FIFO_ERR_EN.
- When defined, adds these ports:
  - write_overflow  out  NUM_VC
  - read_underflow  out  NUM_VC
  - err_clear  in  1
- write_overflow[v] sets sticky on a dropped write to an in-range full VC v.
- read_underflow[v] sets sticky on a dropped read from an in-range empty VC v.
- err_clear=1 clears both vectors on the next edge; a set and a clear in the same cycle resolve as set.
- Both vectors reset to 0.
- When undefined: the three ports do not exist, and drops are silent.

Test Plan (default parameters):
- Reset, then idle → read_empty=2'b11, write_full=2'b00, read_valid=0, data_out=0.
- Write 32'h12345678, 32'h87654321, 32'habcdabcd to VC0, then read VC0 three times → data_out shows the three values in order, each one cycle after its read; read_valid pulses three times; write_almost_full[0] is high after the third write and low after the first read.
- Write 32'haaaaaaaa to VC1 and 32'h11111111 to VC0, then read VC1 first → data_out=32'haaaaaaaa; VC0 is undisturbed and read_empty=2'b10 after the read.
- Fill VC0 with 4 words, then write a 5th word 32'hdeadbeef with a same-cycle read → 5th word dropped; subsequent reads return the original 4 words only; write_overflow[0]=1 when the macro is defined.
- Read an empty VC1 with a same-cycle write of 32'h5 to VC1 → read_valid=0; the next read returns 32'h5; read_underflow[1]=1 when the macro is defined, and err_clear clears it.
- Write 6 words to and read 6 words from VC0 interleaved, crossing the pointer wrap, then pull reset low mid-stream → data stays in order across the wrap; after reset all flags return to reset values and the next read of VC0 is dropped.

Source files
------------

// File: rtl/vc_sync_fifo.sv
// vc_sync_fifo: single-clock FIFO holding NUM_VC independent virtual-channel queues,
// registered read with valid strobe; sticky drop capture when VC_FIFO_ERR_EN is defined.
module vc_sync_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int NUM_VC      = 2,
  parameter int AFULL_LEVEL = 3,
  localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_inc,
  input  logic [VC_W-1:0]       write_vc,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_inc,
  input  logic [VC_W-1:0]       read_vc,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_valid,
  output logic [NUM_VC-1:0]     write_full,
  output logic [NUM_VC-1:0]     write_almost_full,
  output logic [NUM_VC-1:0]     read_empty
`ifdef VC_FIFO_ERR_EN
  ,
  input  logic                  err_clear,
  output logic [NUM_VC-1:0]     write_overflow,
  output logic [NUM_VC-1:0]     read_underflow
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ADDR_W = VC_W + PTR_W;

  logic [DATA_WIDTH-1:0]   mem_q [NUM_VC*DEPTH];
  logic [NUM_VC*PTR_W-1:0] wptr_all;
  logic [NUM_VC*PTR_W-1:0] rptr_all;
  logic [PTR_W-1:0]        wptr_sel;
  logic [PTR_W-1:0]        rptr_sel;
  logic                    wr_full_sel;
  logic                    rd_empty_sel;
  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [ADDR_W-1:0]       waddr;
  logic [ADDR_W-1:0]       raddr;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    read_valid_q;

  // Out-of-range VCs match nothing and therefore look full/empty.
  always_comb begin
    wptr_sel     = '0;
    rptr_sel     = '0;
    wr_full_sel  = 1'b1;
    rd_empty_sel = 1'b1;
    for (int v = 0; v < NUM_VC; v++) begin
      if (write_vc == VC_W'(v)) begin
        wptr_sel    = wptr_all[v*PTR_W +: PTR_W];
        wr_full_sel = write_full[v];
      end
      if (read_vc == VC_W'(v)) begin
        rptr_sel     = rptr_all[v*PTR_W +: PTR_W];
        rd_empty_sel = read_empty[v];
      end
    end
  end

  assign wr_in_range = 32'(write_vc) < NUM_VC;
  assign rd_in_range = 32'(read_vc) < NUM_VC;
  assign wr_acc      = write_inc && wr_in_range && !wr_full_sel;
  assign rd_acc      = read_inc && rd_in_range && !rd_empty_sel;
  assign waddr       = {write_vc, wptr_sel};
  assign raddr       = {read_vc, rptr_sel};

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[waddr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q   <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= rd_acc;
      if (rd_acc) data_out_q <= mem_q[raddr];
    end
  end

  assign data_out   = data_out_q;
  assign read_valid = read_valid_q;

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push;
    logic             pop;

    assign push = wr_acc && (write_vc == VC_W'(gi));
    assign pop  = rd_acc && (read_vc == VC_W'(gi));

    always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PTR_W'(1);
        if (pop)  rptr_q <= rptr_q + PTR_W'(1);
        count_q <= count_d;
      end
    end

    assign wptr_all[gi*PTR_W +: PTR_W] = wptr_q;
    assign rptr_all[gi*PTR_W +: PTR_W] = rptr_q;
    assign write_full[gi]              = (count_q == CNT_W'(DEPTH));
    assign write_almost_full[gi]       = (count_q >= CNT_W'(AFULL_LEVEL));
    assign read_empty[gi]              = (count_q == '0);
  end

`ifdef VC_FIFO_ERR_EN
  logic [NUM_VC-1:0] ovf_q, ovf_d;
  logic [NUM_VC-1:0] unf_q, unf_d;

  // A new drop in the same cycle as err_clear wins over the clear.
  always_comb begin
    ovf_d = err_clear ? '0 : ovf_q;
    unf_d = err_clear ? '0 : unf_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (write_inc && (write_vc == VC_W'(v)) && write_full[v]) ovf_d[v] = 1'b1;
      if (read_inc && (read_vc == VC_W'(v)) && read_empty[v])   unf_d[v] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign write_overflow = ovf_q;
  assign read_underflow = unf_q;
`else
  // Without capture, dropped requests leave no trace.
`endif

endmodule

// File: tb/tb_vc_sync_fifo.sv
// tb_vc_sync_fifo: directed scoreboard bench for vc_sync_fifo at default parameters;
// error-capture outputs are also checked when VC_FIFO_ERR_EN is defined.
module tb_vc_sync_fifo;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_inc = 1'b0;
  logic [0:0]  write_vc = '0;
  logic [31:0] data_in = '0;
  logic        read_inc = 1'b0;
  logic [0:0]  read_vc = '0;
  logic [31:0] data_out;
  logic        read_valid;
  logic [1:0]  write_full;
  logic [1:0]  write_almost_full;
  logic [1:0]  read_empty;
`ifdef VC_FIFO_ERR_EN
  logic        err_clear = 1'b0;
  logic [1:0]  write_overflow;
  logic [1:0]  read_underflow;
  logic [1:0]  exp_ovf = '0;
  logic [1:0]  exp_unf = '0;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [31:0] sb[$];
  logic [31:0] last_data = '0;

  vc_sync_fifo #(
    .DATA_WIDTH(32), .DEPTH(DEPTH), .NUM_VC(2), .AFULL_LEVEL(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .write_inc(write_inc),
    .write_vc(write_vc),
    .data_in(data_in),
    .read_inc(read_inc),
    .read_vc(read_vc),
    .data_out(data_out),
    .read_valid(read_valid),
    .write_full(write_full),
    .write_almost_full(write_almost_full),
    .read_empty(read_empty)
`ifdef VC_FIFO_ERR_EN
    ,
    .err_clear(err_clear),
    .write_overflow(write_overflow),
    .read_underflow(read_underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sz(input logic v);
    return v ? mq1.size() : mq0.size();
  endfunction

  task automatic check_flags();
    logic [1:0] e_empty, e_full, e_af;
    for (int v = 0; v < 2; v++) begin
      e_empty[v] = (sz(v[0]) == 0);
      e_full[v]  = (sz(v[0]) == DEPTH);
      e_af[v]    = (sz(v[0]) >= 3);
    end
    check("read_empty", {30'b0, read_empty}, {30'b0, e_empty});
    check("write_full", {30'b0, write_full}, {30'b0, e_full});
    check("write_almost_full", {30'b0, write_almost_full}, {30'b0, e_af});
`ifdef VC_FIFO_ERR_EN
    check("write_overflow", {30'b0, write_overflow}, {30'b0, exp_ovf});
    check("read_underflow", {30'b0, read_underflow}, {30'b0, exp_unf});
`endif
  endtask

  // One clock of stimulus; the model decides acceptance from its start-of-cycle state.
  task automatic cyc(input logic we, input logic wvc, input logic [31:0] wd,
                     input logic re, input logic rvc);
    logic rd_ok, wr_ok;
    logic [31:0] popped;
    rd_ok = re && (sz(rvc) > 0);
    wr_ok = we && (sz(wvc) < DEPTH);
`ifdef VC_FIFO_ERR_EN
    if (err_clear) begin
      exp_ovf = '0;
      exp_unf = '0;
    end
    if (we && !wr_ok) exp_ovf[wvc] = 1'b1;
    if (re && !rd_ok) exp_unf[rvc] = 1'b1;
`endif
    if (rd_ok) begin
      popped = rvc ? mq1.pop_front() : mq0.pop_front();
      sb.push_back(popped);
    end
    if (wr_ok) begin
      if (wvc) mq1.push_back(wd);
      else     mq0.push_back(wd);
    end
    write_inc = we; write_vc = wvc; data_in = wd;
    read_inc = re;  read_vc = rvc;
    @(posedge clk); #1;
    write_inc = 1'b0; read_inc = 1'b0;
`ifdef VC_FIFO_ERR_EN
    err_clear = 1'b0;
`endif
    if (rd_ok && sb.size() > 0) last_data = sb.pop_front();
    $display("cyc wr=%b wvc=%0d wd=%h rd=%b rvc=%0d -> valid=%b dout=%h empty=%b full=%b afull=%b",
             we, wvc, wd, re, rvc, read_valid, data_out, read_empty, write_full, write_almost_full);
    check("read_valid", {31'b0, read_valid}, {31'b0, rd_ok});
    check("data_out", data_out, last_data);
    check_flags();
  endtask

  // Reset is asserted between edges so the flags must clear without a clock.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    mq0.delete(); mq1.delete(); sb.delete();
    last_data = '0;
`ifdef VC_FIFO_ERR_EN
    exp_ovf = '0;
    exp_unf = '0;
`endif
    $display("reset asserted -> valid=%b dout=%h empty=%b full=%b afull=%b",
             read_valid, data_out, read_empty, write_full, write_almost_full);
    check("rst_read_valid", {31'b0, read_valid}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_read_empty", {30'b0, read_empty}, 32'd3);
    check_flags();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset then idle
    do_reset();
    cyc(0, 0, 0, 0, 0);

    // Three writes to VC0 then three reads
    cyc(1, 0, 32'h12345678, 0, 0);
    cyc(1, 0, 32'h87654321, 0, 0);
    cyc(1, 0, 32'habcdabcd, 0, 0);
    check("afull0_after_3w", {31'b0, write_almost_full[0]}, 32'd1);
    cyc(0, 0, 0, 1, 0);
    check("first_read", data_out, 32'h12345678);
    check("afull0_after_1r", {31'b0, write_almost_full[0]}, 32'd0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("third_read", data_out, 32'habcdabcd);

    // Independent VCs
    cyc(1, 1, 32'haaaaaaaa, 0, 0);
    cyc(1, 0, 32'h11111111, 0, 0);
    cyc(0, 0, 0, 1, 1);
    check("vc1_read", data_out, 32'haaaaaaaa);
    check("empty_after_vc1", {30'b0, read_empty}, 32'd2);
    cyc(0, 0, 0, 1, 0);
    check("vc0_undisturbed", data_out, 32'h11111111);

    // Full VC0: fifth write dropped despite same-cycle read
    for (int i = 0; i < 4; i++) cyc(1, 0, 32'hc0000000 + i, 0, 0);
    cyc(1, 0, 32'hdeadbeef, 1, 0);
    check("full_read0", data_out, 32'hc0000000);
`ifdef VC_FIFO_ERR_EN
    check("ovf0_set", {31'b0, write_overflow[0]}, 32'd1);
`endif
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    check("no_deadbeef", data_out, 32'hc0000003);

    // Empty VC1 read with same-cycle write: read dropped
    cyc(1, 1, 32'h5, 1, 1);
    cyc(0, 0, 0, 1, 1);
    check("vc1_late_read", data_out, 32'h5);
`ifdef VC_FIFO_ERR_EN
    check("unf1_set", {31'b0, read_underflow[1]}, 32'd1);
    err_clear = 1'b1;
    cyc(0, 0, 0, 0, 0);
    check("errs_cleared", {28'b0, write_overflow, read_underflow}, 32'd0);
`endif

    // Interleaved traffic across the pointer wrap, then reset mid-stream
    cyc(1, 0, 32'h60000000, 0, 0);
    for (int i = 1; i < 6; i++) cyc(1, 0, 32'h60000000 + i, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("wrap_last", data_out, 32'h60000005);
    cyc(1, 0, 32'h77777777, 0, 0);
    cyc(1, 1, 32'h88888888, 1, 0);
    do_reset();
    cyc(0, 0, 0, 1, 0);
    check("post_reset_drop", {31'b0, read_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
